multicycle_controller: RTL and testbench

- Moore FSM that sequences the 16-bit accumulator-style multicycle datapath: PC, memory, IR, MDR, A/B, ALU, ALUOut, and the three-register-address register file.
- Consumes Op, Func and Zero from the datapath and drives every datapath enable and mux select.
- Instantiated next to the datapath in the CPU top.
- Also flags retired and illegal instructions for the bench and for the top level.

---
 rtl/multicycle_controller.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Moore control FSM for the 16-bit accumulator multicycle datapath.
// Per-state enables/selects are registered one state ahead; only Zero- and encoding-dependent terms stay combinational.
module multicycle_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Op,
  input  logic [8:0] Func,
  input  logic       Zero,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       OldPCWrite,
  output logic       MDRWrite,
  output logic       A3Src,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       ResultSrc,
  output logic       InstrDone,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MADR, S_MRD, S_MWB, S_MWR,
    S_JMP, S_BEQ, S_EXR, S_EXI, S_RWB, S_HALT
  } state_t;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       old_pc_write;
    logic       mdr_write;
    logic       a3_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_ctl;
    logic [1:0] pc_src;
    logic       result_src;
    logic       instr_done;
  } ctl_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOT   = 3'b100;
  localparam logic [2:0] ALU_PASS1 = 3'b101;
  localparam logic [2:0] ALU_PASS2 = 3'b110;

  localparam logic [3:0] OP_RTYPE = 4'b1000;

  state_t state_q, state_d;
  ctl_t   ctl_q, ctl_d;

  logic func_onehot, func_nop, op_legal, illegal_enc, in_decode;

  // Only bits 0..6 carry real R-type ops; bit 8 alone is the NOP code.
  assign func_onehot = (Func[6:0] != 7'd0) && ((Func[6:0] & (Func[6:0] - 7'd1)) == 7'd0)
                     && (Func[8:7] == 2'b00);
  assign func_nop    = (Op == OP_RTYPE) && (Func == 9'h100);

  always_comb begin
    op_legal = 1'b0;
    case (Op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1100, 4'b1101, 4'b1110, 4'b1111: op_legal = 1'b1;
      OP_RTYPE:                           op_legal = func_onehot | func_nop;
      default:                            op_legal = 1'b0;
    endcase
  end

  assign illegal_enc = ~op_legal;
  assign in_decode   = (state_q == S_DECODE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (illegal_enc)   state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        else if (func_nop) state_d = S_FETCH;
        else begin
          case (Op)
            4'b0000, 4'b0001: state_d = S_MADR;
            4'b0010:          state_d = S_JMP;
            4'b0100:          state_d = S_BEQ;
            OP_RTYPE:         state_d = S_EXR;
            default:          state_d = S_EXI;
          endcase
        end
      end
      S_MADR:   state_d = Op[0] ? S_MWR : S_MRD;
      S_MRD:    state_d = S_MWB;
      S_EXR,
      S_EXI:    state_d = S_RWB;
      S_HALT:   state_d = S_HALT;
      S_MWB, S_MWR, S_JMP, S_BEQ, S_RWB: state_d = S_FETCH;
      default:  state_d = S_RST;
    endcase
  end

  // Decode outputs of the state being entered so they appear registered in that state.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctl_d.ir_write     = 1'b1;
        ctl_d.old_pc_write = 1'b1;
        ctl_d.pc_write     = 1'b1;
        ctl_d.alu_src_b    = 2'b01;
        ctl_d.alu_ctl      = ALU_ADD;
      end
      S_MADR: begin
        ctl_d.alu_src_b = 2'b10;
        ctl_d.alu_ctl   = ALU_PASS2;
      end
      S_MRD: begin
        ctl_d.adr_src   = 1'b1;
        ctl_d.mdr_write = 1'b1;
      end
      S_MWB: begin
        ctl_d.result_src = 1'b1;
        ctl_d.reg_write  = 1'b1;
        ctl_d.instr_done = 1'b1;
      end
      S_MWR: begin
        ctl_d.adr_src    = 1'b1;
        ctl_d.mem_write  = 1'b1;
        ctl_d.instr_done = 1'b1;
      end
      S_JMP: begin
        ctl_d.pc_src     = 2'b01;
        ctl_d.pc_write   = 1'b1;
        ctl_d.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctl_d.alu_src_a  = 2'b10;
        ctl_d.alu_ctl    = ALU_SUB;
        ctl_d.pc_src     = 2'b10;
        ctl_d.instr_done = 1'b1;
      end
      S_EXR: begin
        ctl_d.alu_src_a = 2'b10;
        if (Func[0]) begin
          ctl_d.alu_src_b = 2'b10;
          ctl_d.alu_ctl   = ALU_PASS1;
        end
        else if (Func[1]) ctl_d.alu_ctl = ALU_PASS2;
        else if (Func[2]) ctl_d.alu_ctl = ALU_ADD;
        else if (Func[3]) ctl_d.alu_ctl = ALU_SUB;
        else if (Func[4]) ctl_d.alu_ctl = ALU_AND;
        else if (Func[5]) ctl_d.alu_ctl = ALU_OR;
        else              ctl_d.alu_ctl = ALU_NOT;
      end
      S_EXI: begin
        ctl_d.alu_src_a = 2'b10;
        ctl_d.alu_src_b = 2'b10;
        ctl_d.imm_src   = 2'b01;
        ctl_d.alu_ctl   = {1'b0, Op[1:0]};
      end
      S_RWB: begin
        ctl_d.reg_write  = 1'b1;
        ctl_d.instr_done = 1'b1;
        ctl_d.a3_src     = (Op == OP_RTYPE) && Func[0];
      end
      default: ctl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  assign AdrSrc     = ctl_q.adr_src;
  assign MemWrite   = ctl_q.mem_write;
  assign IRWrite    = ctl_q.ir_write;
  assign RegWrite   = ctl_q.reg_write;
  assign PCWrite    = ctl_q.pc_write | ((state_q == S_BEQ) & Zero);
  assign OldPCWrite = ctl_q.old_pc_write;
  assign MDRWrite   = ctl_q.mdr_write;
  assign A3Src      = ctl_q.a3_src;
  assign ALUSrcA    = ctl_q.alu_src_a;
  assign ALUSrcB    = ctl_q.alu_src_b;
  assign ImmSrc     = ctl_q.imm_src;
  assign ALUControl = ctl_q.alu_ctl;
  assign PCSrc      = ctl_q.pc_src;
  assign ResultSrc  = ctl_q.result_src;
  assign InstrDone  = ctl_q.instr_done | (in_decode & (illegal_enc | func_nop));
  assign Illegal    = in_decode & illegal_enc;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-instruction expected control vectors are queued at issue and popped each cycle.
module tb_multicycle_controller;

  typedef struct packed {
    logic       adr_src, mem_write, ir_write, reg_write, pc_write, old_pc_write, mdr_write, a3_src;
    logic [1:0] alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_ctl;
    logic [1:0] pc_src;
    logic       result_src, instr_done, illegal;
  } ctl_t;

  typedef struct {
    string      tag;
    ctl_t       exp;
    bit         ld;
    logic [3:0] op;
    logic [8:0] fn;
    logic       z;
  } sb_t;

  logic       clk = 1'b0;
  logic [1:0] rstn;
  logic [3:0] Op;
  logic [8:0] Func;
  logic       Zero;
  ctl_t       outv [2];
  bit         sel2 = 1'b0;
  int         checks = 0, errors = 0;
  sb_t        sbq[$];

  always #5 clk = ~clk;

  // Instance 0 retires illegal encodings as no-ops, instance 1 traps them.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       AdrSrc, MemWrite, IRWrite, RegWrite, PCWrite, OldPCWrite, MDRWrite, A3Src;
    logic       ResultSrc, InstrDone, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, PCSrc;
    logic [2:0] ALUControl;
    multicycle_controller #(.ILLEGAL_TRAP(g == 1)) u_dut (
      .clk(clk), .reset(rstn[g]), .Op(Op), .Func(Func), .Zero(Zero),
      .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .PCWrite(PCWrite), .OldPCWrite(OldPCWrite), .MDRWrite(MDRWrite), .A3Src(A3Src),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .PCSrc(PCSrc), .ResultSrc(ResultSrc), .InstrDone(InstrDone), .Illegal(Illegal)
    );
    assign outv[g] = {AdrSrc, MemWrite, IRWrite, RegWrite, PCWrite, OldPCWrite, MDRWrite, A3Src,
                      ALUSrcA, ALUSrcB, ImmSrc, ALUControl, PCSrc, ResultSrc, InstrDone, Illegal};
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%06h, expected 0x%06h", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input ctl_t c);
    sb_t e;
    e.tag = tag; e.exp = c; e.ld = 1'b0; e.op = '0; e.fn = '0; e.z = 1'b0;
    sbq.push_back(e);
  endtask

  // Builds the expected per-cycle vectors for one instruction from the state table.
  task automatic issue(input logic [3:0] op, input logic [8:0] fn, input logic z, input string tag);
    ctl_t c;
    bit   nop, oh, ill;
    nop = (op == 4'b1000) && (fn == 9'h100);
    oh  = (op == 4'b1000) && ($countones(fn) == 1) && (fn[8:7] == 2'b00);
    ill = !((op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'hC, 4'hD, 4'hE, 4'hF}) || nop || oh);
    c = '0; c.ir_write = 1; c.old_pc_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01;
    push({tag, ".fetch"}, c);
    sbq[sbq.size()-1].ld = 1'b1;
    sbq[sbq.size()-1].op = op;
    sbq[sbq.size()-1].fn = fn;
    sbq[sbq.size()-1].z  = z;
    c = '0; c.instr_done = ill || nop; c.illegal = ill;
    push({tag, ".decode"}, c);
    if (ill || nop) return;
    c = '0;
    case (op)
      4'h0, 4'h1: begin
        c.alu_src_b = 2'b10; c.alu_ctl = 3'b110;
        push({tag, ".madr"}, c);
        if (op == 4'h0) begin
          c = '0; c.adr_src = 1; c.mdr_write = 1;
          push({tag, ".mrd"}, c);
          c = '0; c.result_src = 1; c.reg_write = 1; c.instr_done = 1;
          push({tag, ".mwb"}, c);
        end else begin
          c = '0; c.adr_src = 1; c.mem_write = 1; c.instr_done = 1;
          push({tag, ".mwr"}, c);
        end
      end
      4'h2: begin
        c.pc_src = 2'b01; c.pc_write = 1; c.instr_done = 1;
        push({tag, ".jmp"}, c);
      end
      4'h4: begin
        c.alu_src_a = 2'b10; c.alu_ctl = 3'b001; c.pc_src = 2'b10; c.pc_write = z; c.instr_done = 1;
        push({tag, ".beq"}, c);
      end
      4'h8: begin
        c.alu_src_a = 2'b10;
        case (fn)
          9'h001:  begin c.alu_src_b = 2'b10; c.alu_ctl = 3'b101; end
          9'h002:  c.alu_ctl = 3'b110;
          9'h004:  c.alu_ctl = 3'b000;
          9'h008:  c.alu_ctl = 3'b001;
          9'h010:  c.alu_ctl = 3'b010;
          9'h020:  c.alu_ctl = 3'b011;
          default: c.alu_ctl = 3'b100;
        endcase
        push({tag, ".exr"}, c);
        c = '0; c.reg_write = 1; c.instr_done = 1; c.a3_src = (fn == 9'h001);
        push({tag, ".rwb"}, c);
      end
      default: begin
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; c.imm_src = 2'b01;
        case (op)
          4'hC:    c.alu_ctl = 3'b000;
          4'hD:    c.alu_ctl = 3'b001;
          4'hE:    c.alu_ctl = 3'b010;
          default: c.alu_ctl = 3'b011;
        endcase
        push({tag, ".exi"}, c);
        c = '0; c.reg_write = 1; c.instr_done = 1;
        push({tag, ".rwb"}, c);
      end
    endcase
  endtask

  // One queue entry per cycle; the fetch entry also loads the emulated IR fields.
  task automatic drain(input int n);
    for (int i = 0; i < n && sbq.size() > 0; i++) begin
      sb_t e;
      @(negedge clk);
      e = sbq.pop_front();
      chk(e.tag, sel2 ? outv[1] : outv[0], e.exp);
      if (e.ld) begin
        Op = e.op; Func = e.fn; Zero = e.z;
      end
    end
  endtask

  initial begin
    rstn = 2'b00; Op = '0; Func = '0; Zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset.trap0", outv[0], '0);
      chk("reset.trap1", outv[1], '0);
    end
    @(posedge clk); #1 rstn[0] = 1'b1;
    push("rst", '0);
    issue(4'h0, 9'h05A, 1'b0, "load");
    issue(4'h1, 9'h033, 1'b0, "store");
    issue(4'h2, 9'h1FF, 1'b1, "jump");
    issue(4'h4, 9'h003, 1'b1, "beq_taken");
    issue(4'h4, 9'h003, 1'b0, "beq_not");
    issue(4'h8, 9'h001, 1'b0, "moveto");
    issue(4'h8, 9'h002, 1'b0, "movefrom");
    issue(4'h8, 9'h004, 1'b0, "add");
    issue(4'h8, 9'h008, 1'b0, "sub");
    issue(4'h8, 9'h010, 1'b0, "and");
    issue(4'h8, 9'h020, 1'b0, "or");
    issue(4'h8, 9'h040, 1'b0, "not");
    issue(4'h8, 9'h100, 1'b0, "nop");
    issue(4'h8, 9'h003, 1'b0, "ill_fn3");
    issue(4'h8, 9'h000, 1'b0, "ill_fn0");
    issue(4'h8, 9'h080, 1'b0, "ill_fn7");
    issue(4'h3, 9'h004, 1'b0, "ill_op3");
    issue(4'hC, 9'h1FF, 1'b0, "addi");
    issue(4'hD, 9'h0A5, 1'b1, "subi");
    issue(4'hE, 9'h100, 1'b0, "andi");
    issue(4'hF, 9'h001, 1'b0, "ori");
    drain(1000);

    // Abort a LOAD once it has reached MRD, between clock edges.
    issue(4'h0, 9'h05A, 1'b0, "abort");
    drain(3);
    @(posedge clk); #2 rstn[0] = 1'b0;
    #1 chk("abort.async", outv[0], '0);
    sbq.delete();
    repeat (2) begin
      @(negedge clk);
      chk("abort.hold", outv[0], '0);
    end
    @(posedge clk); #1 rstn[0] = 1'b1;
    push("abort.rst", '0);
    issue(4'h8, 9'h004, 1'b0, "resume");
    drain(1000);

    // Trapping instance: illegal op, then illegal Func after a fresh reset.
    sel2 = 1'b1;
    @(posedge clk); #1 rstn[1] = 1'b1;
    push("trap.rst", '0);
    issue(4'h3, 9'h000, 1'b0, "trap_op");
    repeat (10) push("trap.halt", '0);
    drain(1000);
    @(posedge clk); #1 rstn[1] = 1'b0;
    @(posedge clk); #1 rstn[1] = 1'b1;
    push("trap.rst2", '0);
    issue(4'h8, 9'h003, 1'b0, "trap_fn");
    repeat (10) push("trap.halt2", '0);
    drain(1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
